// File: rtl/chip8_timer_pkg.sv
// Shared types for the CHIP-8 tick/timer block.
// Timer select encoding and default timer width.
package chip8_timer_pkg;

   typedef enum logic {
      TIMER_DELAY = 1'b0,
      TIMER_SOUND = 1'b1
   } timer_sel_t;

   localparam int TIMER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser + rising-edge detector with post-reset blanking.
// Ports: clk_in, rst_in (sync, active-high), async_in, rise_out (registered, 1 cycle).
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic async_in,
   output logic rise_out
);

   localparam int CW = $clog2(STAGES + 2);
   localparam logic [CW-1:0] BLANK_INIT = CW'(STAGES + 1);

   logic [STAGES-1:0] sync_q;
   logic              edge_q;
   logic [CW-1:0]     blank_q;
   logic              rise_q;
   logic              sync_last;
   logic              blank_done;

   assign sync_last  = sync_q[STAGES-1];
   assign blank_done = (blank_q == '0);

   // Edge flop keeps following the chain during blanking so a level
   // that is already high at reset release is never seen as an edge.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_q  <= '0;
         edge_q  <= 1'b0;
         blank_q <= BLANK_INIT;
         rise_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         edge_q <= sync_last;
         if (!blank_done)
            blank_q <= blank_q - CW'(1);
         rise_q <= sync_last & ~edge_q & blank_done;
      end
   end

   assign rise_out = rise_q;

endmodule

// File: rtl/tick_timer_unit.sv
// CHIP-8 delay/sound timers decremented by ticks from a divided slow clock.
// Ports: clk_in, rst_in, tick_clk_in, halt_in, wr_en/sel/data_in -> delay/sound/beep/tick_out.
module tick_timer_unit
   import chip8_timer_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMER_WIDTH = TIMER_WIDTH_DEFAULT
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   tick_clk_in,
   input  logic                   halt_in,
   input  logic                   wr_en_in,
   input  logic                   wr_sel_in,
   input  logic [TIMER_WIDTH-1:0] wr_data_in,
   output logic [TIMER_WIDTH-1:0] delay_out,
   output logic [TIMER_WIDTH-1:0] sound_out,
   output logic                   beep_out,
   output logic                   tick_out
);

   logic                   rise;
   logic                   tick;
   timer_sel_t             sel;
   logic                   wr_delay;
   logic                   wr_sound;
   logic [TIMER_WIDTH-1:0] delay_q;
   logic [TIMER_WIDTH-1:0] sound_q;
   logic [TIMER_WIDTH-1:0] delay_nx;
   logic [TIMER_WIDTH-1:0] sound_nx;
   logic                   beep_q;

   sync_edge_detect #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .async_in (tick_clk_in),
      .rise_out (rise)
   );

   // Halt drops the tick outright; the edge detector has already
   // moved on, so nothing is queued for later.
   assign tick = rise & ~halt_in;

   assign sel      = timer_sel_t'(wr_sel_in);
   assign wr_delay = wr_en_in & (sel == TIMER_DELAY);
   assign wr_sound = wr_en_in & (sel == TIMER_SOUND);

   // Load beats decrement; zero saturates.
   always_comb begin
      delay_nx = delay_q;
      if (wr_delay)
         delay_nx = wr_data_in;
      else if (tick && (delay_q != '0))
         delay_nx = delay_q - TIMER_WIDTH'(1);
   end

   always_comb begin
      sound_nx = sound_q;
      if (wr_sound)
         sound_nx = wr_data_in;
      else if (tick && (sound_q != '0))
         sound_nx = sound_q - TIMER_WIDTH'(1);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         delay_q <= '0;
         sound_q <= '0;
         beep_q  <= 1'b0;
      end else begin
         delay_q <= delay_nx;
         sound_q <= sound_nx;
         beep_q  <= (sound_nx != '0);
      end
   end

   assign delay_out = delay_q;
   assign sound_out = sound_q;
   assign beep_out  = beep_q;
   assign tick_out  = tick;

endmodule

// File: tb/tb_tick_timer_unit.sv
// Self-checking bench for tick_timer_unit.
// Table vectors, directed corner sequences and random traffic vs a model.
module tb_tick_timer_unit;

   localparam int S = 2;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         tclk;
   logic         halt;
   logic         wr_en;
   logic         wr_sel;
   logic [W-1:0] wr_data;
   logic [W-1:0] delay_out;
   logic [W-1:0] sound_out;
   logic         beep_out;
   logic         tick_out;

   tick_timer_unit #(
      .SYNC_STAGES (S),
      .TIMER_WIDTH (W)
   ) dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .tick_clk_in (tclk),
      .halt_in     (halt),
      .wr_en_in    (wr_en),
      .wr_sel_in   (wr_sel),
      .wr_data_in  (wr_data),
      .delay_out   (delay_out),
      .sound_out   (sound_out),
      .beep_out    (beep_out),
      .tick_out    (tick_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: history of slow-clock samples since reset, one per edge.
   bit           samp[$];
   int           nedge;
   bit           m_rise;
   logic [W-1:0] md;
   logic [W-1:0] ms;
   bit           mb;

   typedef struct {
      bit           en;
      bit           sel;
      logic [W-1:0] data;
      logic [W-1:0] d;
      logic [W-1:0] s;
      bit           b;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock edge: advance the model with the inputs present before
   // the edge, then compare every output just after it.
   task automatic step();
      bit tk;
      tk = m_rise & ~halt;
      @(posedge clk);
      if (rst) begin
         samp.delete();
         samp.push_back(1'b0);
         nedge  = 0;
         m_rise = 0;
         md     = '0;
         ms     = '0;
         mb     = 0;
      end else begin
         if (wr_en && !wr_sel) md = wr_data;
         else if (tk && md != 0) md = md - 1;
         if (wr_en && wr_sel) ms = wr_data;
         else if (tk && ms != 0) ms = ms - 1;
         mb = (ms != 0);
         nedge++;
         samp.push_back(tclk);
         // A rising edge sampled S edges ago, once blanking has expired.
         m_rise = (nedge >= S + 2) && samp[nedge-S] && !samp[nedge-S-1];
      end
      #1;
      chk("tick", int'(tick_out), int'(m_rise & ~halt));
      chk("delay", int'(delay_out), int'(md));
      chk("sound", int'(sound_out), int'(ms));
      chk("beep", int'(beep_out), int'(mb));
   endtask

   task automatic idle();
      wr_en   = 0;
      wr_sel  = 0;
      wr_data = '0;
   endtask

   task automatic wr(input bit sel, input logic [W-1:0] d);
      wr_en   = 1;
      wr_sel  = sel;
      wr_data = d;
      step();
      idle();
   endtask

   initial begin
      int cnt;
      bit found;
      rst  = 1;
      tclk = 1;
      halt = 0;
      idle();
      tbl[0] = '{1, 0, 8'h03, 8'h03, 8'h00, 0};
      tbl[1] = '{1, 1, 8'h02, 8'h03, 8'h02, 1};
      tbl[2] = '{0, 0, 8'h00, 8'h03, 8'h02, 1};
      tbl[3] = '{1, 1, 8'h00, 8'h03, 8'h00, 0};
      tbl[4] = '{1, 0, 8'hff, 8'hff, 8'h00, 0};
      tbl[5] = '{1, 1, 8'h80, 8'hff, 8'h80, 1};
      tbl[6] = '{0, 1, 8'h55, 8'hff, 8'h80, 1};
      tbl[7] = '{1, 0, 8'h00, 8'h00, 8'h80, 1};

      // Reset with slow clock high; no tick after release.
      step();
      step();
      chk("rst_delay", int'(delay_out), 0);
      chk("rst_beep", int'(beep_out), 0);
      rst = 0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tick_out) cnt++;
      end
      chk("t1_no_tick", cnt, 0);

      // Table of writes with no ticks.
      tclk = 0;
      repeat (6) step();
      for (int i = 0; i < 8; i++) begin
         wr_en   = tbl[i].en;
         wr_sel  = tbl[i].sel;
         wr_data = tbl[i].data;
         step();
         chk($sformatf("tbl%0d_d", i), int'(delay_out), int'(tbl[i].d));
         chk($sformatf("tbl%0d_s", i), int'(sound_out), int'(tbl[i].s));
         chk($sformatf("tbl%0d_b", i), int'(beep_out), int'(tbl[i].b));
      end
      idle();

      // Toggle every 8 clocks: four rising edges in 64 cycles.
      wr(0, 8'd3);
      wr(1, 8'd2);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         tclk = ((i / 8) % 2) == 1;
         step();
         if (tick_out) cnt++;
      end
      chk("t2_tick_count", cnt, 4);
      chk("t3_delay_end", int'(delay_out), 0);
      chk("t3_sound_end", int'(sound_out), 0);
      chk("t3_beep_end", int'(beep_out), 0);

      // Write delay in a tick cycle while sound is 7.
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_rise) begin
            found = 1;
         end else begin
            wr_en   = 1;
            wr_sel  = 1;
            wr_data = 8'd7;
            tclk    = ((i / 8) % 2) == 1;
            step();
         end
      end
      chk("t4_found_tick", int'(found), 1);
      wr(0, 8'd5);
      chk("t4_delay", int'(delay_out), 5);
      chk("t4_sound", int'(sound_out), 6);

      // Halt across three rising edges, then one more edge.
      tclk = 0;
      repeat (8) step();
      wr(0, 8'd10);
      halt = 1;
      cnt  = 0;
      for (int i = 0; i < 48; i++) begin
         tclk = ((i / 8) % 2) == 1;
         step();
         if (tick_out) cnt++;
      end
      chk("t5_halt_ticks", cnt, 0);
      chk("t5_halt_delay", int'(delay_out), 10);
      halt = 0;
      for (int i = 48; i < 64; i++) begin
         tclk = ((i / 8) % 2) == 1;
         step();
      end
      chk("t5_after_halt", int'(delay_out), 9);

      // Reset mid-count.
      wr(1, 8'd9);
      chk("t6_beep_pre", int'(beep_out), 1);
      rst = 1;
      step();
      rst = 0;
      chk("t6_sound", int'(sound_out), 0);
      chk("t6_beep", int'(beep_out), 0);
      chk("t6_tick", int'(tick_out), 0);
      tclk = 1;
      cnt  = 0;
      for (int i = 0; i < S + 1; i++) begin
         step();
         if (tick_out) cnt++;
      end
      chk("t6_blank", cnt, 0);

      // Random traffic.
      cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (cnt == 0) begin
            tclk = ~tclk;
            cnt  = int'($urandom_range(3, 12));
         end
         cnt--;
         halt    = ($urandom_range(0, 9) == 0);
         rst     = ($urandom_range(0, 99) == 0);
         wr_en   = ($urandom_range(0, 9) == 0);
         wr_sel  = $urandom_range(0, 1) == 1;
         wr_data = W'($urandom_range(0, 5));
         step();
      end
      rst = 0;
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
